// File: rtl/obstacle_spawner_pkg.sv
// Shared definitions for the obstacle spawning slice: screen geometry,
// obstacle type encodings, spawner FSM states and random-value helpers.
package obstacle_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int OBST_SIZE = 32;

  typedef enum logic [1:0] {
    OBST_NONE = 2'd0,
    OBST_ROCK = 2'd1,
    OBST_LOG  = 2'd2,
    OBST_CAR  = 2'd3
  } obst_type_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PICK,
    STALL,
    EMIT
  } spawner_state_e;

  // A raw value of zero would mean "no obstacle", so it folds onto a rock.
  function automatic obst_type_e type_from_rand(input logic [1:0] raw);
    return (raw == 2'd0) ? OBST_ROCK : obst_type_e'(raw);
  endfunction

  // Raw x spans 0..1020 in steps of 4; the upper band folds back by 512 so
  // the result stays on screen and keeps 4-pixel alignment.
  function automatic logic [9:0] start_x_from_rand(input logic [7:0] raw,
                                                   input logic [9:0] x_max);
    logic [9:0] x;
    x = {raw, 2'b00};
    return (x > x_max) ? x - 10'd512 : x;
  endfunction

endpackage

// File: rtl/obstacle_spawner_if.sv
// Spawn interface between the spawner (master) and the per-slot obstacle
// motion controllers (slave), which report back which slots are occupied.
interface obstacle_spawner_if #(
  parameter int NUM_SLOTS = 4
) ();

  logic [NUM_SLOTS-1:0] spawn_slot;
  logic [1:0]           obstacle_trigger;
  logic [9:0]           obstacle_start_x;
  logic [9:0]           obstacle_start_y;
  logic [NUM_SLOTS-1:0] slot_busy;

  modport master (
    output spawn_slot,
    output obstacle_trigger,
    output obstacle_start_x,
    output obstacle_start_y,
    input  slot_busy
  );

  modport slave (
    input  spawn_slot,
    input  obstacle_trigger,
    input  obstacle_start_x,
    input  obstacle_start_y,
    output slot_busy
  );

endinterface

// File: rtl/obstacle_spawner_lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400), free-running every cycle out of reset.
// Reusable by any block that needs cheap pseudo-random bits.
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  // Load the seed in reset, otherwise shift right and fold taps on a set LSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= seed;
    end else if (out[0]) begin
      out <= {1'b0, out[15:1]} ^ 16'hB400;
    end else begin
      out <= {1'b0, out[15:1]};
    end
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: paced by frame ticks, it picks the lowest free obstacle
// slot, draws a random type and start x, and fires a one-cycle one-hot spawn
// pulse. Every DIFF_STEP spawns the interval shrinks towards MIN_INTERVAL.
module obstacle_spawner
  import obstacle_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int SEED          = 16'hACE1,
  parameter int INIT_INTERVAL = 60,
  parameter int MIN_INTERVAL  = 16,
  parameter int INTERVAL_DEC  = 4,
  parameter int DIFF_STEP     = 8,
  parameter int START_Y       = 0,
  parameter int X_MAX         = SCREEN_W - OBST_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                frame_tick,
  obstacle_spawner_if.master  bus,
  output logic [7:0]          spawn_interval
);

  localparam logic [7:0]  INIT_IV    = 8'(INIT_INTERVAL);
  localparam logic [8:0]  MIN_IV     = 9'(MIN_INTERVAL);
  localparam logic [8:0]  DEC_IV     = 9'(INTERVAL_DEC);
  localparam logic [7:0]  LAST_SPAWN = 8'(DIFF_STEP - 1);
  localparam logic [9:0]  START_Y_V  = 10'(START_Y);
  localparam logic [9:0]  X_MAX_V    = 10'(X_MAX);
  localparam logic [15:0] SEED_V     = 16'(SEED);

  spawner_state_e       state;
  logic [15:0]          lfsr;
  logic [7:0]           frame_cnt;
  logic [7:0]           spawn_cnt;
  logic [NUM_SLOTS-1:0] free_slots;
  logic [NUM_SLOTS-1:0] pick_onehot;
  logic [7:0]           next_interval;
  logic                 unused_lfsr_bits;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED_V),
    .out   (lfsr)
  );

  assign unused_lfsr_bits = ^{lfsr[15:12], lfsr[1:0]};

  // Lowest free slot as a one-hot mask, and the next (floored) interval.
  always_comb begin
    free_slots  = ~bus.slot_busy;
    // x & -x isolates the lowest set bit, i.e. the lowest-index free slot.
    pick_onehot = free_slots & (~free_slots + NUM_SLOTS'(1));
    if ({1'b0, spawn_interval} >= MIN_IV + DEC_IV) begin
      next_interval = spawn_interval - DEC_IV[7:0];
    end else begin
      next_interval = MIN_IV[7:0];
    end
  end

  // Spawn FSM with registered outputs, frame pacing and difficulty ramp.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      frame_cnt            <= '0;
      spawn_cnt            <= '0;
      spawn_interval       <= INIT_IV;
      bus.spawn_slot       <= '0;
      bus.obstacle_trigger <= OBST_NONE;
      bus.obstacle_start_x <= '0;
      bus.obstacle_start_y <= '0;
    end else begin
      bus.spawn_slot <= '0;

      // The emitted pulse always counts, even if enable drops in that cycle.
      if (state == EMIT) begin
        if (spawn_cnt == LAST_SPAWN) begin
          spawn_cnt      <= '0;
          spawn_interval <= next_interval;
        end else begin
          spawn_cnt <= spawn_cnt + 8'd1;
        end
      end

      if (!enable) begin
        state                <= IDLE;
        frame_cnt            <= '0;
        bus.obstacle_trigger <= OBST_NONE;
        bus.obstacle_start_x <= '0;
        bus.obstacle_start_y <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= WAIT;
          end
          WAIT: begin
            if (frame_tick) begin
              if (frame_cnt == spawn_interval - 8'd1) begin
                frame_cnt <= '0;
                state     <= PICK;
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
          end
          PICK: begin
            if (|free_slots) begin
              bus.spawn_slot       <= pick_onehot;
              bus.obstacle_trigger <= type_from_rand(lfsr[11:10]);
              bus.obstacle_start_x <= start_x_from_rand(lfsr[9:2], X_MAX_V);
              bus.obstacle_start_y <= START_Y_V;
              state                <= EMIT;
            end else begin
              state <= STALL;
            end
          end
          STALL: begin
            if (|free_slots) begin
              state <= PICK;
            end
          end
          EMIT: begin
            state <= WAIT;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: two instances (INIT_INTERVAL = 3 and defaults)
// share stimulus; a cycle-level reference model predicts every output, and
// directed scenarios pin key behaviour with literal expectations.
module tb_obstacle_spawner;

  localparam int M_OFF     = 0;
  localparam int M_COUNT   = 1;
  localparam int M_CHOOSE  = 2;
  localparam int M_BLOCKED = 3;
  localparam int M_FIRE    = 4;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       enable     = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] busy       = 4'b0000;
  logic [7:0] iv_a;
  logic [7:0] iv_b;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  bit chk_on   = 1'b0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int m_phase [2];
  int m_frames[2];
  int m_iv    [2];
  int m_cnt   [2];
  int m_lfsr  [2];
  int m_slot  [2];
  int m_trig  [2];
  int m_x     [2];
  int m_y     [2];
  int init_iv [2] = '{3, 60};

  obstacle_spawner_if #(.NUM_SLOTS(4)) if_a ();
  obstacle_spawner_if #(.NUM_SLOTS(4)) if_b ();

  assign if_a.slot_busy = busy;
  assign if_b.slot_busy = busy;

  obstacle_spawner #(.INIT_INTERVAL(3)) dut_a (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .frame_tick     (frame_tick),
    .bus            (if_a),
    .spawn_interval (iv_a)
  );

  obstacle_spawner dut_b (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .frame_tick     (frame_tick),
    .bus            (if_b),
    .spawn_interval (iv_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of the behavioural model, from the rules of the spawner.
  task automatic model_step(input int m);
    int cur;
    int pick;
    if (reset) begin
      m_phase[m] = M_OFF;  m_frames[m] = 0; m_iv[m] = init_iv[m]; m_cnt[m] = 0;
      m_lfsr[m]  = 'hACE1; m_slot[m] = 0;   m_trig[m] = 0; m_x[m] = 0; m_y[m] = 0;
    end else begin
      cur       = m_lfsr[m];
      m_lfsr[m] = (cur & 1) ? ((cur >> 1) ^ 'hB400) : (cur >> 1);
      m_slot[m] = 0;
      if (m_phase[m] == M_FIRE) begin
        m_cnt[m]++;
        if (m_cnt[m] == 8) begin
          m_cnt[m] = 0;
          m_iv[m]  = (m_iv[m] - 4 < 16) ? 16 : m_iv[m] - 4;
        end
      end
      if (!enable) begin
        m_phase[m] = M_OFF; m_frames[m] = 0; m_trig[m] = 0; m_x[m] = 0; m_y[m] = 0;
      end else begin
        case (m_phase[m])
          M_OFF:   m_phase[m] = M_COUNT;
          M_COUNT: if (frame_tick) begin
                     m_frames[m]++;
                     if (m_frames[m] == m_iv[m]) begin
                       m_frames[m] = 0;
                       m_phase[m]  = M_CHOOSE;
                     end
                   end
          M_CHOOSE: begin
            pick = -1;
            for (int i = 3; i >= 0; i--) if (!busy[i]) pick = i;
            if (pick >= 0) begin
              m_slot[m] = 1 << pick;
              m_trig[m] = ((cur >> 10) & 3) == 0 ? 1 : ((cur >> 10) & 3);
              m_x[m]    = ((cur >> 2) & 255) * 4;
              if (m_x[m] > 608) m_x[m] = m_x[m] - 512;
              m_y[m]     = 0;
              m_phase[m] = M_FIRE;
            end else begin
              m_phase[m] = M_BLOCKED;
            end
          end
          M_BLOCKED: if (busy != 4'b1111) m_phase[m] = M_CHOOSE;
          default:   m_phase[m] = M_COUNT;
        endcase
      end
    end
  endtask

  task automatic compare_dut(input string tag, input int m, input logic [3:0] slot,
                             input logic [1:0] trig, input logic [9:0] x,
                             input logic [9:0] y, input logic [7:0] iv);
    check({tag, ".spawn_slot"}, slot, m_slot[m]);
    check({tag, ".trigger"},    trig, m_trig[m]);
    check({tag, ".start_x"},    x,    m_x[m]);
    check({tag, ".start_y"},    y,    m_y[m]);
    check({tag, ".interval"},   iv,   m_iv[m]);
  endtask

  // Advance the model on the same edge the DUTs sample their inputs.
  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Count spawn pulses; DUT registers still hold pre-edge values here.
  always @(posedge clk) begin
    if (|if_a.spawn_slot) pulses_a++;
    if (|if_b.spawn_slot) pulses_b++;
  end

  // Compare both DUTs against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (chk_on) begin
      compare_dut("a", 0, if_a.spawn_slot, if_a.obstacle_trigger, if_a.obstacle_start_x,
                  if_a.obstacle_start_y, iv_a);
      compare_dut("b", 1, if_b.spawn_slot, if_b.obstacle_trigger, if_b.obstacle_start_x,
                  if_b.obstacle_start_y, iv_b);
    end
  end

  task automatic ticks_only(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (9) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  // n ticks ten cycles apart, then expect dut_a's pulse two cycles after the last.
  task automatic ticks_then_expect(input int n, input logic [3:0] exp_slot,
                                   output logic [1:0] t, output logic [9:0] x);
    int p0;
    p0 = pulses_a;
    ticks_only(n);
    check("pre_emit_quiet", pulses_a - p0, 0);
    check("pre_emit_slot", if_a.spawn_slot, 0);
    @(negedge clk);
    check("emit_slot", if_a.spawn_slot, exp_slot);
    t = if_a.obstacle_trigger;
    x = if_a.obstacle_start_x;
    check("type_in_range", (t >= 2'd1 && t <= 2'd3), 1);
    check("x_in_range", (x <= 10'd608), 1);
    check("x_aligned", x[1:0], 0);
    check("y_value", if_a.obstacle_start_y, 0);
    @(negedge clk);
    check("pulse_width", if_a.spawn_slot, 0);
  endtask

  task automatic fresh_start_spawn(output logic [1:0] t, output logic [9:0] x);
    reset  = 1'b1;
    enable = 1'b0;
    busy   = 4'b0000;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    ticks_then_expect(3, 4'b0001, t, x);
  endtask

  initial begin
    logic [1:0] t0, t1, tt;
    logic [9:0] x0, x1, xx;
    int p, base, cycles, min_iv;
    bit found, c8;

    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_slot_a", if_a.spawn_slot, 0);
    check("rst_trig_a", if_a.obstacle_trigger, 0);
    check("rst_x_a", if_a.obstacle_start_x, 0);
    check("rst_y_a", if_a.obstacle_start_y, 0);
    check("rst_iv_a", iv_a, 3);
    check("rst_iv_b", iv_b, 60);

    // Disabled: ticks must produce nothing.
    reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
    check("idle_pulses_a", pulses_a, 0);
    check("idle_pulses_b", pulses_b, 0);
    check("idle_trig_b", if_b.obstacle_trigger, 0);
    check("idle_iv_b", iv_b, 60);

    // First spawn after reset.
    fresh_start_spawn(t0, x0);

    // Enable dropped after 2 of 3 ticks: needs 3 fresh ticks.
    ticks_only(2);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    ticks_then_expect(3, 4'b0001, tt, xx);

    // Slots 0 and 1 busy.
    busy = 4'b0011;
    ticks_then_expect(3, 4'b0100, tt, xx);

    // All busy, then slot 2 released.
    busy = 4'b1111;
    ticks_only(3);
    repeat (3) @(negedge clk);
    p = pulses_a;
    repeat (20) @(negedge clk);
    check("stall_no_pulse", pulses_a - p, 0);
    busy  = 4'b1011;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (if_a.spawn_slot == 4'b0100) found = 1'b1;
    end
    check("stall_release", found, 1);

    // Reset while stalled, then the random sequence must repeat.
    busy = 4'b1111;
    ticks_only(3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("stall_rst_slot", if_a.spawn_slot, 0);
    check("stall_rst_trig", if_a.obstacle_trigger, 0);
    check("stall_rst_x", if_a.obstacle_start_x, 0);
    check("stall_rst_iv_a", iv_a, 3);
    check("stall_rst_iv_b", iv_b, 60);
    fresh_start_spawn(t1, x1);
    check("repeat_type", t1, t0);
    check("repeat_x", x1, x0);

    // Randomised run until dut_b has spawned 120 obstacles.
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    base   = pulses_b;
    cycles = 0;
    min_iv = 255;
    c8     = 1'b0;
    while (cycles < 60000 && (pulses_b - base) < 120) begin
      @(negedge clk);
      if (!c8 && (pulses_b - base) >= 8) begin
        check("iv_after_8", iv_b, 56);
        check("model_iv_after_8", m_iv[1], 56);
        c8 = 1'b1;
      end
      if (int'(iv_b) < min_iv) min_iv = int'(iv_b);
      frame_tick = 1'($urandom_range(0, 1));
      busy       = 4'($urandom & $urandom);
      enable     = ($urandom_range(0, 1999) != 0);
      cycles++;
    end
    check("random_done", (pulses_b - base) >= 120, 1);
    check("iv_saturated", iv_b, 16);
    check("iv_min_floor", min_iv, 16);

    frame_tick = 1'b0;
    enable     = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
